// File: rtl/vector_processing_block.sv
// rtl/vector_processing_block.sv - lane-wise SIMD vector processor with handshaked load/store ports
// Optional cycle/stall counters are compiled in with VECTOR_PROCESSING_BLOCK_PERF_EN.
module vector_processing_block #(
  parameter int LANES    = 32,
  parameter int LANE_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  output logic [ADDR_W-1:0]         instr_addr_o,
  input  logic [31:0]               instr_data_i,
  output logic                      load_ctrl_o,
  output logic [ADDR_W-1:0]         load_addr_o,
  input  logic                      load_valid_i,
  input  logic [LANES*LANE_W-1:0]   load_data_i,
  output logic                      write_ctrl_o,
  output logic [ADDR_W-1:0]         write_addr_o,
  output logic [LANES*LANE_W-1:0]   write_data_o,
  input  logic                      write_ready_i,
  output logic                      finished_o,
  output logic                      error_o
`ifdef VECTOR_PROCESSING_BLOCK_PERF_EN
  ,
  output logic [31:0]               cycle_count_o,
  output logic [31:0]               stall_count_o
`endif
);

  localparam int VW     = LANES * LANE_W;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_STORE = 8'h10;
  localparam logic [7:0] OP_LOAD  = 8'h20;
  localparam logic [7:0] OP_MOV   = 8'h30;
  localparam logic [7:0] OP_BNZD  = 8'h40;

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_LOAD_WAIT, S_STORE_WAIT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              load_ctrl_q, load_ctrl_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic              write_ctrl_q, write_ctrl_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [VW-1:0]     write_data_q, write_data_d;
  logic              error_q, error_d;

  logic [VW-1:0]     rf_q [NUM_REGS];
  logic              rf_we;
  logic [VW-1:0]     rf_wdata;

  logic [7:0]        op, d_idx, a_idx, b_idx;
  logic [VW-1:0]     rd_a, rd_b, rd_d;
  logic [VW-1:0]     alu_res;
  logic [LANE_W-1:0] dec_lane0;
  logic              legal;

  function automatic logic idx_ok(input logic [7:0] idx);
    return {24'd0, idx} < NUM_REGS;
  endfunction

  assign op    = ir_q[31:24];
  assign d_idx = ir_q[23:16];
  assign a_idx = ir_q[15:8];
  assign b_idx = ir_q[7:0];

  // Reads are from the pre-write register state, so d==a/b sees old values.
  assign rd_a = rf_q[a_idx[RIDX_W-1:0]];
  assign rd_b = rf_q[b_idx[RIDX_W-1:0]];
  assign rd_d = rf_q[d_idx[RIDX_W-1:0]];
  assign dec_lane0 = rd_d[LANE_W-1:0] - LANE_W'(1);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_HALT:                legal = 1'b1;
      OP_ADD, OP_MUL, OP_SUB: legal = idx_ok(d_idx) && idx_ok(a_idx) && idx_ok(b_idx);
      OP_LOAD:                legal = idx_ok(d_idx) && idx_ok(a_idx);
      OP_STORE, OP_MOV, OP_BNZD: legal = idx_ok(d_idx);
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    for (int i = 0; i < LANES; i++) begin
      case (op)
        OP_ADD:  alu_res[i*LANE_W +: LANE_W] = rd_a[i*LANE_W +: LANE_W] + rd_b[i*LANE_W +: LANE_W];
        OP_MUL:  alu_res[i*LANE_W +: LANE_W] = rd_a[i*LANE_W +: LANE_W] * rd_b[i*LANE_W +: LANE_W];
        OP_SUB:  alu_res[i*LANE_W +: LANE_W] = rd_a[i*LANE_W +: LANE_W] - rd_b[i*LANE_W +: LANE_W];
        default: alu_res[i*LANE_W +: LANE_W] = '0;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (!legal)              state_d = S_DONE;
        else if (op == OP_HALT)  state_d = S_DONE;
        else if (op == OP_LOAD)  state_d = S_LOAD_WAIT;
        else if (op == OP_STORE) state_d = S_STORE_WAIT;
        else                     state_d = S_FETCH;
      end
      S_LOAD_WAIT:  if (load_valid_i)  state_d = S_FETCH;
      S_STORE_WAIT: if (write_ready_i) state_d = S_FETCH;
      default:      state_d = S_DONE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    load_ctrl_d  = load_ctrl_q;
    load_addr_d  = load_addr_q;
    write_ctrl_d = write_ctrl_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    error_d      = error_q;
    rf_we        = 1'b0;
    rf_wdata     = '0;
    case (state_q)
      S_FETCH: ir_d = instr_data_i;
      S_EXEC: begin
        if (!legal) begin
          error_d = 1'b1;
        end else begin
          case (op)
            OP_ADD, OP_MUL, OP_SUB: begin
              rf_we    = 1'b1;
              rf_wdata = alu_res;
              pc_d     = pc_q + ADDR_W'(1);
            end
            OP_MOV: begin
              rf_we    = 1'b1;
              rf_wdata = {LANES{LANE_W'(ir_q[15:0])}};
              pc_d     = pc_q + ADDR_W'(1);
            end
            OP_BNZD: begin
              rf_we    = 1'b1;
              rf_wdata = {rd_d[VW-1:LANE_W], dec_lane0};
              pc_d     = (dec_lane0 != '0) ? ADDR_W'(ir_q[15:0]) : pc_q + ADDR_W'(1);
            end
            OP_LOAD: begin
              load_ctrl_d = 1'b1;
              load_addr_d = ADDR_W'(rd_a[LANE_W-1:0]);
            end
            OP_STORE: begin
              write_ctrl_d = 1'b1;
              write_addr_d = ADDR_W'(ir_q[15:0]);
              write_data_d = rd_d;
            end
            default: ;
          endcase
        end
      end
      S_LOAD_WAIT: begin
        if (load_valid_i) begin
          rf_we       = 1'b1;
          rf_wdata    = load_data_i;
          load_ctrl_d = 1'b0;
          pc_d        = pc_q + ADDR_W'(1);
        end
      end
      S_STORE_WAIT: begin
        if (write_ready_i) begin
          write_ctrl_d = 1'b0;
          pc_d         = pc_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q         <= '0;
      ir_q         <= '0;
      load_ctrl_q  <= 1'b0;
      load_addr_q  <= '0;
      write_ctrl_q <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      error_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      load_ctrl_q  <= load_ctrl_d;
      load_addr_q  <= load_addr_d;
      write_ctrl_q <= write_ctrl_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      error_q      <= error_d;
      if (rf_we) rf_q[d_idx[RIDX_W-1:0]] <= rf_wdata;
    end
  end

  assign instr_addr_o = pc_q;
  assign load_ctrl_o  = load_ctrl_q;
  assign load_addr_o  = load_addr_q;
  assign write_ctrl_o = write_ctrl_q;
  assign write_addr_o = write_addr_q;
  assign write_data_o = write_data_q;
  assign finished_o   = (state_q == S_DONE);
  assign error_o      = error_q;

`ifdef VECTOR_PROCESSING_BLOCK_PERF_EN
  logic [31:0] cycle_q, cycle_d, stall_q, stall_d;
  logic        stalled;

  assign stalled = ((state_q == S_LOAD_WAIT) && !load_valid_i) ||
                   ((state_q == S_STORE_WAIT) && !write_ready_i);

  // Both counters saturate and freeze once the program halts.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (state_q != S_DONE) begin
      if (cycle_q != '1)            cycle_d = cycle_q + 32'd1;
      if (stalled && stall_q != '1) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  assign cycle_count_o = cycle_q;
  assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_vector_processing_block.sv
// tb/tb_vector_processing_block.sv - scoreboard bench for vector_processing_block
// Counter checks are included when VECTOR_PROCESSING_BLOCK_PERF_EN is defined.
module tb_vector_processing_block;

  localparam int LANES  = 32;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 16;
  localparam int VW     = LANES * LANE_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VW-1:0]     data;
  } st_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] instr_addr;
  logic [31:0]       instr_data;
  logic              load_ctrl, load_valid, write_ctrl, write_ready, finished, error;
  logic [ADDR_W-1:0] load_addr, write_addr;
  logic [VW-1:0]     load_data, write_data;
`ifdef VECTOR_PROCESSING_BLOCK_PERF_EN
  logic [31:0]       cycle_count, stall_count;
`endif

  logic [31:0]       rom [64];
  logic [ADDR_W-1:0] ld_q [$];
  st_t               st_q [$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;
  assign instr_data = rom[instr_addr[5:0]];

  vector_processing_block dut (
    .clock_i       (clk),
    .reset_ni      (reset_n),
    .instr_addr_o  (instr_addr),
    .instr_data_i  (instr_data),
    .load_ctrl_o   (load_ctrl),
    .load_addr_o   (load_addr),
    .load_valid_i  (load_valid),
    .load_data_i   (load_data),
    .write_ctrl_o  (write_ctrl),
    .write_addr_o  (write_addr),
    .write_data_o  (write_data),
    .write_ready_i (write_ready),
    .finished_o    (finished),
    .error_o       (error)
`ifdef VECTOR_PROCESSING_BLOCK_PERF_EN
    ,
    .cycle_count_o (cycle_count),
    .stall_count_o (stall_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [LANE_W-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [VW-1:0] lane_seq(input int mult);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = LANE_W'(i * mult);
    return r;
  endfunction

  function automatic logic [VW-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    case (a)
      16'd0:   return fill(16'h0005);
      16'd1:   return fill(16'h0007);
      16'd2:   return lane_seq(32'h111);
      default: return fill(a);
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] a, input logic [7:0] b);
    return {op, d, a, b};
  endfunction

  function automatic logic [31:0] enci(input logic [7:0] op, input logic [7:0] d, input logic [15:0] imm);
    return {op, d, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic push_st(input logic [ADDR_W-1:0] a, input logic [VW-1:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    st_q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    load_valid  = 1'b0;
    write_ready = 1'b0;
    load_data   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_instr_addr", instr_addr, 0);
    check_eq("rst_load_ctrl",  load_ctrl, 0);
    check_eq("rst_write_ctrl", write_ctrl, 0);
    check_eq("rst_write_data", write_data, 0);
    check_eq("rst_finished",   finished, 0);
    check_eq("rst_error",      error, 0);
`ifdef VECTOR_PROCESSING_BLOCK_PERF_EN
    check_eq("rst_cycle_count", cycle_count, 0);
    check_eq("rst_stall_count", stall_count, 0);
`endif
    reset_n = 1'b1;
  endtask

  // Memory responder plus scoreboard checks; returns early on the first store when abort_st is set.
  task automatic run_prog(input int ld_stall, input int st_stall, input bit abort_st, input bit exp_err);
    int lw, sw, cyc;
    bit aborted;
    logic [ADDR_W-1:0] la_hold, ia_hold, sa_hold;
    st_t e;
    lw = 0; sw = 0; cyc = 0; aborted = 0;
    la_hold = '0; ia_hold = '0; sa_hold = '0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (finished) break;
      if (load_ctrl) begin
        if (lw == 0) begin
          la_hold = load_addr;
          ia_hold = instr_addr;
          check_eq("load_expected", ld_q.size() != 0, 1);
          if (ld_q.size() != 0) check_eq("load_addr", load_addr, ld_q.pop_front());
        end else begin
          check_eq("load_addr_stable",  load_addr, la_hold);
          check_eq("instr_addr_stable", instr_addr, ia_hold);
        end
        if (lw >= ld_stall) begin
          load_valid = 1'b1;
          load_data  = mem_rd(load_addr);
        end
        lw++;
      end else begin
        load_valid = 1'b0;
        lw = 0;
      end
      if (write_ctrl) begin
        if (sw == 0) begin
          sa_hold = write_addr;
          check_eq("store_expected", st_q.size() != 0, 1);
          if (st_q.size() != 0) begin
            e = st_q.pop_front();
            check_eq("store_addr", write_addr, e.addr);
            check_eq("store_data", write_data, e.data);
          end
          if (abort_st) begin
            aborted = 1;
            break;
          end
        end else begin
          check_eq("store_addr_stable", write_addr, sa_hold);
        end
        write_ready = (sw >= st_stall);
        sw++;
      end else begin
        write_ready = 1'b0;
        sw = 0;
      end
    end
    if (!aborted) begin
      check_eq("finished",       finished, 1);
      check_eq("error",          error, exp_err);
      check_eq("loads_pending",  ld_q.size(), 0);
      check_eq("stores_pending", st_q.size(), 0);
    end
    load_valid  = 1'b0;
    write_ready = 1'b0;
  endtask

  task automatic load_main();
    clear_rom();
    rom[0] = enci(8'h30, 8, 16'h0);
    rom[1] = enci(8'h30, 9, 16'h1);
    rom[2] = enc(8'h20, 0, 8, 0);
    rom[3] = enc(8'h20, 1, 9, 0);
    rom[4] = enci(8'h30, 2, 16'h3e4d);
    rom[5] = enc(8'h02, 3, 0, 1);
    rom[6] = enc(8'h01, 4, 3, 2);
    rom[7] = enci(8'h10, 4, 16'h3);
    rom[8] = 32'h0;
    ld_q.push_back(16'd0);
    ld_q.push_back(16'd1);
    push_st(16'h3, fill(16'h3e70));
  endtask

  task automatic err_test(input logic [31:0] instr, input string tag);
    clear_rom();
    rom[0] = instr;
    do_reset();
    @(negedge clk);
    check_eq({tag, "_not_yet_done"}, finished, 0);
    @(negedge clk);
    check_eq({tag, "_finished"},   finished, 1);
    check_eq({tag, "_error"},      error, 1);
    check_eq({tag, "_write_ctrl"}, write_ctrl, 0);
    check_eq({tag, "_load_ctrl"},  load_ctrl, 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_sticky"},     {finished, error, instr_addr}, {1'b1, 1'b1, 16'h0});
  endtask

  initial begin
    reset_n     = 1'b0;
    load_valid  = 1'b0;
    write_ready = 1'b0;
    load_data   = '0;
    clear_rom();

    load_main();
    do_reset();
    run_prog(0, 0, 0, 0);

    clear_rom();
    rom[0] = enci(8'h30, 5, 16'h3);
    rom[1] = enci(8'h30, 6, 16'h0);
    rom[2] = enci(8'h30, 7, 16'h1);
    rom[3] = enc(8'h01, 6, 6, 7);
    rom[4] = enci(8'h40, 5, 16'h3);
    rom[5] = enci(8'h10, 6, 16'h10);
    rom[6] = 32'h0;
    push_st(16'h10, fill(16'h0003));
    do_reset();
    run_prog(0, 2, 0, 0);

    clear_rom();
    rom[0]  = enci(8'h30, 0, 16'hffff);
    rom[1]  = enci(8'h30, 1, 16'h0002);
    rom[2]  = enc(8'h01, 2, 0, 1);
    rom[3]  = enci(8'h10, 2, 16'h20);
    rom[4]  = enci(8'h30, 3, 16'h0000);
    rom[5]  = enci(8'h30, 4, 16'h0001);
    rom[6]  = enc(8'h03, 5, 3, 4);
    rom[7]  = enci(8'h10, 5, 16'h21);
    rom[8]  = enci(8'h30, 6, 16'h0100);
    rom[9]  = enc(8'h02, 7, 6, 6);
    rom[10] = enci(8'h10, 7, 16'h22);
    rom[11] = enci(8'h30, 10, 16'h2);
    rom[12] = enc(8'h20, 11, 10, 0);
    rom[13] = enc(8'h01, 11, 11, 11);
    rom[14] = enci(8'h10, 11, 16'h23);
    rom[15] = 32'h0;
    push_st(16'h20, fill(16'h0001));
    push_st(16'h21, fill(16'hffff));
    push_st(16'h22, fill(16'h0000));
    ld_q.push_back(16'd2);
    push_st(16'h23, lane_seq(32'h222));
    do_reset();
    run_prog(1, 0, 0, 0);

    clear_rom();
    rom[0] = enci(8'h30, 8, 16'h0);
    rom[1] = enc(8'h20, 0, 8, 0);
    rom[2] = enci(8'h10, 0, 16'h30);
    rom[3] = 32'h0;
    ld_q.push_back(16'd0);
    push_st(16'h30, fill(16'h0005));
    do_reset();
    run_prog(5, 0, 0, 0);
`ifdef VECTOR_PROCESSING_BLOCK_PERF_EN
    check_eq("stall_count", stall_count, 5);
    check_eq("cycle_count", cycle_count, 15);
    repeat (3) @(negedge clk);
    check_eq("cycle_count_frozen", cycle_count, 15);
`endif

    err_test(32'h7f000000, "bad_opcode");
    err_test(enc(8'h01, 20, 1, 2), "bad_reg");

    load_main();
    do_reset();
    run_prog(0, 1000, 1, 0);
    check_eq("mid_store_write_ctrl_set", write_ctrl, 1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_write_ctrl", write_ctrl, 0);
    check_eq("async_rst_instr_addr", instr_addr, 0);
    check_eq("async_rst_finished",   finished, 0);
    ld_q.delete();
    st_q.delete();
    load_main();
    do_reset();
    run_prog(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_processing_block.md
Name: vector_processing_block

Overview:
- Parametrised successor to the single-issue SIMD processing block.
- Fetches 32-bit instructions from an external instruction port and executes lane-wise integer vector ops over a register file.
- Moves vectors to and from main memory through valid/ready handshakes instead of fixed-latency strobes.
- Adds SUB, a decrement-and-branch loop op, an error flag and stall-tolerant memory access; sits between the sequencer's instruction ROM and the shared main memory.

Parameters:
- LANES, 32, number of SIMD lanes.
- LANE_W, 16, bits per lane.
- NUM_REGS, 16, vector registers (2..256).
- ADDR_W, 16, main-memory and PC address width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_addr  out  ADDR_W  PC presented to the instruction ROM.
- instr_data  in  32  instruction, combinational read of instr_addr.
- load_ctrl  out  1  load request.
- load_addr  out  ADDR_W  load address.
- load_valid  in  1  load_data valid; completes the load.
- load_data  in  LANES*LANE_W  loaded vector.
- write_ctrl  out  1  store request.
- write_addr  out  ADDR_W  store address.
- write_data  out  LANES*LANE_W  store vector.
- write_ready  in  1  memory accepted the store.
- finished  out  1  program halted.
- error  out  1  halted on an illegal instruction.

Behaviour:
- Reset (async, reset=0): PC=0, all registers 0, state FETCH, every output 0. Outputs drop immediately, mid-handshake included. Execution restarts at PC 0 on the first edge after release.
- Instruction fields: [31:24] op, [23:16] d, [15:8] a, [7:0] b, [15:0] imm.
- Opcodes:
  - 0x00 HALT.
  - 0x01 ADD r[d]=r[a]+r[b].
  - 0x02 MUL r[d]=low LANE_W bits of r[a]*r[b].
  - 0x03 SUB r[d]=r[a]-r[b].
  - 0x10 STORE r[d] to address imm.
  - 0x20 LOAD r[d] from address r[a] lane0[ADDR_W-1:0].
  - 0x30 MOV imm, zero-extended/truncated to LANE_W, broadcast to all lanes of r[d].
  - 0x40 BNZD: r[d] lane0 -= 1 (other lanes kept); if result != 0 then PC=imm, else PC+1.
- Arithmetic is lane-wise, unsigned, modulo 2^LANE_W.
- FETCH (1 cycle): instr_addr=PC; latch instr_data into IR; go to EXEC.
- EXEC (1 cycle):
  - ALU/MOV/BNZD: write register, update PC, go to FETCH. Two cycles per instruction.
  - LOAD: register load_ctrl=1 and load_addr, go to LOAD_WAIT.
  - STORE: register write_ctrl=1, write_addr=imm, write_data=r[d], go to STORE_WAIT.
  - HALT: go to DONE.
  - Unknown opcode, or any used register index >= NUM_REGS: error=1, go to DONE. No register or memory side effect.
- LOAD_WAIT: hold load_ctrl, load_addr stable. On a clock edge with load_valid=1: r[d]=load_data, load_ctrl=0, PC+1, go to FETCH. Minimum load is 3 cycles. load_valid outside LOAD_WAIT is ignored.
- STORE_WAIT: hold write_ctrl, write_addr, write_data stable until an edge with write_ready=1; then write_ctrl=0, PC+1, go to FETCH. write_ready outside STORE_WAIT is ignored.
- DONE: finished=1 (and error if set). Sticky until reset; no further fetches; instr_addr holds.
- PC wraps 2^ADDR_W-1 -> 0.
- A register read and written by the same instruction reads the old value.
- Lane i occupies bits [i*LANE_W +: LANE_W].

Optional Feature:
- Macro: VECTOR_PROCESSING_BLOCK_PERF_EN.
- Defined:
  - Adds outputs cycle_count (32) and stall_count (32), both reset to 0.
  - cycle_count increments every cycle outside DONE.
  - stall_count increments on each LOAD_WAIT cycle with load_valid=0 and each STORE_WAIT cycle with write_ready=0.
  - Both saturate at 0xFFFFFFFF and freeze in DONE.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Defaults; program MOV r8,0; MOV r9,1; LOAD r0,[r8]; LOAD r1,[r9]; MOV r2,0x3e4d; MUL r3,r0,r1; ADD r4,r3,r2; STORE r4,3; HALT. load_valid=1 immediately, data 0x0005 then 0x0007 per lane -> load_addr 0 then 1, write_addr=3, every lane 0x3e70, then finished=1, error=0.
- LOAD with load_valid held 0 for 5 cycles -> load_ctrl=1, load_addr constant, instr_addr constant. Completes on the edge load_valid rises. With PERF_EN, stall_count=5.
- Loop: MOV r5,3; MOV r6,0; MOV r7,1; ADD r6,r6,r7; BNZD r5,3; STORE r6,0x10; HALT -> exactly one store, addr 0x10, all lanes 0x0003.
- Wrap: lanes 0xFFFF+0x0002 -> 0x0001; 0x0000-0x0001 -> 0xFFFF; 0x0100*0x0100 -> 0x0000.
- Opcode 0x7F, or ADD with d=20 (NUM_REGS=16) -> finished=1 and error=1 two cycles after fetch. No write_ctrl, no register change.
- Drop reset mid STORE_WAIT (write_ready=0) -> write_ctrl=0 with no clock edge. After release, instr_addr=0 and the program re-runs with identical results.
